seven_seg_bank: RTL and testbench

//  Multi-digit 7-segment driver for the clock display: holds a shadow copy of N hex digits.

---
 rtl/seven_seg_bank.sv | 148 ++++++++++++++
 tb/tb_seven_seg_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_bank.sv
// seven_seg_bank
//   Multi-digit 7-segment driver for the clock display. Holds a shadow copy of
//   NUM_DIGITS hex digits plus their display attributes, and decodes them to
//   active-low segments. It also handles per-digit dot, enable, leading-zero
//   blanking, per-digit blink and global PWM dimming. All outputs are registered.
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   load         1 = capture value/dot_en/digit_en/blink_mask/lz_suppress/brightness
//   value        digit i nibble at [4i+3:4i]
//   dot_en       1 = light dot of digit i
//   digit_en     1 = digit i active
//   blink_mask   1 = digit i blinks
//   lz_suppress  1 = blank leading zeros
//   brightness   PWM duty, 0 = off, all-ones = always on
//   segments     digit i at [7i+6:7i], bit6=a .. bit0=g, active low
//   dots         active-low dot per digit
//   blink_phase  1 = blinking digits hidden
module seven_seg_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int PWM_BITS   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dot_en,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lz_suppress,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic [7*NUM_DIGITS-1:0]   segments,
    output logic [NUM_DIGITS-1:0]     dots,
    output logic                      blink_phase
);

    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_dot_en;
    logic [NUM_DIGITS-1:0]   sh_digit_en;
    logic [NUM_DIGITS-1:0]   sh_blink_mask;
    logic                    sh_lz;
    logic [PWM_BITS-1:0]     sh_brightness;

    logic [BLINK_W-1:0]      blink_cnt;
    logic [PWM_BITS-1:0]     pwm_cnt;

    logic                    lit;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [7*NUM_DIGITS-1:0] seg_nxt;
    logic [NUM_DIGITS-1:0]   dots_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0000010;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_value      <= '0;
            sh_dot_en     <= '0;
            sh_digit_en   <= '0;
            sh_blink_mask <= '0;
            sh_lz         <= 1'b0;
            sh_brightness <= '1;
            blink_cnt     <= '0;
            blink_phase   <= 1'b0;
            pwm_cnt       <= '0;
            segments      <= '1;
            dots          <= '1;
        end else begin
            if (load) begin
                sh_value      <= value;
                sh_dot_en     <= dot_en;
                sh_digit_en   <= digit_en;
                sh_blink_mask <= blink_mask;
                sh_lz         <= lz_suppress;
                sh_brightness <= brightness;
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
            pwm_cnt  <= pwm_cnt + 1'b1;
            segments <= seg_nxt;
            dots     <= dots_nxt;
        end
    end

    assign lit = (&sh_brightness) || (pwm_cnt < sh_brightness);

    // Leading-zero scan from the top digit down. A disabled digit reads as zero;
    // a lit dot or any nonzero digit ends the run. Digit 0 is never scanned.
    always_comb begin
        logic scanning;
        lz_blank = '0;
        scanning = sh_lz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (scanning && !sh_dot_en[i] &&
                (!sh_digit_en[i] || sh_value[4*i +: 4] == 4'h0)) begin
                lz_blank[i] = 1'b1;
            end else begin
                scanning = 1'b0;
            end
        end
    end

    // The dot is hidden by disable, blink and PWM but survives LZ blanking.
    always_comb begin
        logic hide;
        seg_nxt  = '1;
        dots_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hide = !sh_digit_en[i] || (blink_phase && sh_blink_mask[i]) || !lit;
            if (hide || lz_blank[i]) begin
                seg_nxt[7*i +: 7] = 7'h7F;
            end else begin
                seg_nxt[7*i +: 7] = decode(sh_value[4*i +: 4]);
            end
            dots_nxt[i] = hide ? 1'b1 : !sh_dot_en[i];
        end
    end

endmodule

// File: tb/tb_seven_seg_bank.sv
module tb_seven_seg_bank;

    localparam int ND = 6;
    localparam int BD = 4;
    localparam int PB = 2;

    localparam logic [6:0] C0 = 7'b0000001, C1 = 7'b1001111, C2 = 7'b0010010, C3 = 7'b0000110;
    localparam logic [6:0] C4 = 7'b1001100, C5 = 7'b0100100, C6 = 7'b0100000, C7 = 7'b0001111;
    localparam logic [6:0] C8 = 7'b0000000, C9 = 7'b0000100, CA = 7'b0000010, CB = 7'b1100000;
    localparam logic [6:0] CC = 7'b0110001, CD = 7'b1000010, CE = 7'b0110000, CF = 7'b0111000;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] CODES [16] = '{C0, C1, C2, C3, C4, C5, C6, C7,
                                          C8, C9, CA, CB, CC, CD, CE, CF};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   dot_en;
    logic [ND-1:0]   digit_en;
    logic [ND-1:0]   blink_mask;
    logic            lz_suppress;
    logic [PB-1:0]   brightness;
    logic [7*ND-1:0] segments;
    logic [ND-1:0]   dots;
    logic            blink_phase;

    int errors = 0;
    int checks = 0;

    // reference model state: shadow registers and edges since the last reset
    logic [23:0] m_value;
    logic [5:0]  m_dot, m_en, m_mask;
    logic        m_lz;
    logic [1:0]  m_br;
    int          m_n = 0;

    seven_seg_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .PWM_BITS(PB)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dot_en(dot_en),
        .digit_en(digit_en), .blink_mask(blink_mask), .lz_suppress(lz_suppress),
        .brightness(brightness), .segments(segments), .dots(dots),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Display rules evaluated directly: phase and PWM count follow from the
    // number of edges since reset.
    function automatic void model_out(input int n, output logic [41:0] seg, output logic [5:0] dt);
        bit phase, lit, run, lzb, hidden;
        int pc, nib;
        phase = ((n / BD) % 2) == 1;
        pc    = n % (1 << PB);
        lit   = (m_br == 2'd3) || (pc < int'(m_br));
        run   = m_lz;
        seg   = '1;
        dt    = '1;
        for (int d = ND - 1; d >= 0; d--) begin
            nib = int'((m_value >> (4 * d)) & 24'hF);
            lzb = (d > 0) && run && !m_dot[d] && (!m_en[d] || nib == 0);
            if (!lzb) run = 1'b0;
            hidden = !m_en[d] || (phase && m_mask[d]) || !lit;
            seg[7*d +: 7] = (hidden || lzb) ? BL : CODES[nib];
            dt[d] = hidden ? 1'b1 : !m_dot[d];
        end
    endfunction

    task automatic tick();
        logic [41:0] es;
        logic [5:0]  ed;
        logic        ep;
        @(posedge clk);
        if (!rst_n) begin
            es = '1; ed = '1; m_n = 0;
            m_value = '0; m_dot = '0; m_en = '0; m_mask = '0; m_lz = 1'b0; m_br = 2'd3;
        end else begin
            model_out(m_n, es, ed);
            if (load) begin
                m_value = value; m_dot = dot_en; m_en = digit_en;
                m_mask = blink_mask; m_lz = lz_suppress; m_br = brightness;
            end
            m_n++;
        end
        ep = ((m_n / BD) % 2) == 1;
        #1;
        check("model_seg", 64'(segments), 64'(es));
        check("model_dots", 64'(dots), 64'(ed));
        check("model_phase", 64'(blink_phase), 64'(ep));
    endtask

    typedef struct {
        logic [23:0] value;
        logic [5:0]  dot_en;
        logic [5:0]  digit_en;
        logic        lz;
        logic [1:0]  br;
        logic [41:0] seg;
        logic [5:0]  dots;
    } vec_t;

    vec_t vecs [9];

    task automatic apply(input vec_t v);
        value = v.value; dot_en = v.dot_en; digit_en = v.digit_en;
        lz_suppress = v.lz; brightness = v.br; blink_mask = '0;
        load = 1'b1; tick();
        load = 1'b0; tick();
    endtask

    initial begin
        int cnt, tog, chg;
        logic prev_ph;
        logic [6:0] d5;
        bit found;

        vecs[0] = '{24'h543210, 6'h00, 6'h3F, 1'b0, 2'd3, {C5, C4, C3, C2, C1, C0}, 6'h3F};
        vecs[1] = '{24'hBA9876, 6'h00, 6'h3F, 1'b0, 2'd3, {CB, CA, C9, C8, C7, C6}, 6'h3F};
        vecs[2] = '{24'hFEDCBA, 6'h2A, 6'h3F, 1'b0, 2'd3, {CF, CE, CD, CC, CB, CA}, 6'h15};
        vecs[3] = '{24'h000105, 6'h00, 6'h3F, 1'b1, 2'd3, {BL, BL, BL, C1, C0, C5}, 6'h3F};
        vecs[4] = '{24'h000105, 6'h10, 6'h3F, 1'b1, 2'd3, {BL, C0, C0, C1, C0, C5}, 6'h2F};
        vecs[5] = '{24'h123456, 6'h00, 6'h33, 1'b0, 2'd3, {C1, C2, BL, BL, C5, C6}, 6'h3F};
        vecs[6] = '{24'h7000A0, 6'h00, 6'h1F, 1'b1, 2'd3, {BL, BL, BL, BL, CA, C0}, 6'h3F};
        vecs[7] = '{24'h000000, 6'h00, 6'h3F, 1'b1, 2'd3, {BL, BL, BL, BL, BL, C0}, 6'h3F};
        vecs[8] = '{24'h543210, 6'h3F, 6'h3F, 1'b0, 2'd0, {6{BL}}, 6'h3F};

        // reset with load asserted: load is discarded
        rst_n = 1'b0; load = 1'b1; value = 24'h987654; dot_en = '1; digit_en = '1;
        blink_mask = '1; lz_suppress = 1'b0; brightness = '1;
        tick(); tick();
        check("rst_seg", 64'(segments), 64'({42{1'b1}}));
        check("rst_dots", 64'(dots), 64'h3F);
        check("rst_phase", 64'(blink_phase), 64'h0);
        rst_n = 1'b1; load = 1'b0;
        tick(); tick();
        check("rst_shadow_clear", 64'(segments), 64'({42{1'b1}}));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check($sformatf("vec%0d_seg", i), 64'(segments), 64'(vecs[i].seg));
            check($sformatf("vec%0d_dots", i), 64'(dots), 64'(vecs[i].dots));
        end

        // blink: digit0 hidden 8 of 16 cycles, 4 phase toggles, digit5 steady
        apply(vecs[0]);
        blink_mask = 6'b000001; load = 1'b1; tick(); load = 1'b0; tick();
        cnt = 0; tog = 0; chg = 0; prev_ph = blink_phase; d5 = segments[41:35];
        for (int k = 0; k < 16; k++) begin
            tick();
            if (segments[6:0] == BL) cnt++;
            if (blink_phase != prev_ph) tog++;
            if (segments[41:35] != d5) chg++;
            prev_ph = blink_phase;
        end
        check("blink_hidden_cycles", 64'(cnt), 64'd8);
        check("blink_toggles", 64'(tog), 64'd4);
        check("blink_other_steady", 64'(chg), 64'd0);

        // PWM duty
        blink_mask = '0;
        for (int b = 0; b < 4; b++) begin
            brightness = 2'(b); load = 1'b1; tick(); load = 1'b0; tick();
            cnt = 0;
            for (int k = 0; k < 16; k++) begin
                tick();
                if (segments[6:0] != BL) cnt++;
            end
            check($sformatf("pwm_lit_b%0d", b), 64'(cnt), 64'(b == 3 ? 16 : 4 * b));
        end

        // reset mid-run during blink_phase=1
        blink_mask = 6'b000001; brightness = 2'd3; load = 1'b1; tick(); load = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (blink_phase) found = 1'b1;
        end
        check("wait_phase1", 64'(found), 64'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("midrst_seg", 64'(segments), 64'({42{1'b1}}));
        check("midrst_dots", 64'(dots), 64'h3F);
        check("midrst_phase", 64'(blink_phase), 64'h0);
        tick();
        check("midrst_shadow", 64'(segments), 64'({42{1'b1}}));
        apply(vecs[0]);
        check("midrst_reload", 64'(segments), 64'(vecs[0].seg));

        // random stimulus against the model
        for (int k = 0; k < 400; k++) begin
            rst_n       = ($urandom_range(0, 49) != 0);
            load        = ($urandom_range(0, 3) == 0);
            value       = 24'($urandom);
            if ($urandom_range(0, 1) == 1) value = value & 24'h00F0FF;
            dot_en      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
            digit_en    = 6'($urandom) | 6'h21;
            blink_mask  = 6'($urandom);
            lz_suppress = 1'($urandom);
            brightness  = 2'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
